// File: rtl/filter_sequencer.sv
// filter_sequencer: walks a padded input image window by window, issuing the
// WS*WS tap reads for each output pixel, waiting for the filter result and
// writing it to the result image, for every pixel of every colour plane.
//
// Ports:
//   Control_CLK     clock, rising edge
//   Control_RST     asynchronous active-high reset
//   Control_STRT    start a job (sampled only while idle)
//   Control_ABORT   abandon the current job, back to idle without DNE
//   Control_MEMREQ  memory request valid
//   Control_MEMACK  memory accepted the request at this edge
//   Control_MEMRW   2'b10 read, 2'b01 write, 2'b00 idle
//   Control_MEMADDR request address
//   Control_FEN     filter enable, covers the tap reads and the result wait
//   Control_WLAST   the read being requested is the last window tap
//   Control_FDNE    filter result ready
//   Control_CH      current colour plane
//   Control_BUSY    job in progress
//   Control_DNE     one-cycle job-complete pulse
module filter_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned WINDOW_SIZE  = 3,
  parameter int unsigned IMAGE_WIDTH  = 512,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned RESULT_BASE  = CHANNELS * (IMAGE_WIDTH + WINDOW_SIZE - 1)
                                                 * (IMAGE_HEIGHT + WINDOW_SIZE - 1)
) (
  input  logic                  Control_CLK,
  input  logic                  Control_RST,
  input  logic                  Control_STRT,
  input  logic                  Control_ABORT,
  output logic                  Control_MEMREQ,
  input  logic                  Control_MEMACK,
  output logic [1:0]            Control_MEMRW,
  output logic [ADDR_WIDTH-1:0] Control_MEMADDR,
  output logic                  Control_FEN,
  output logic                  Control_WLAST,
  input  logic                  Control_FDNE,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] Control_CH,
  output logic                  Control_BUSY,
  output logic                  Control_DNE
);

  localparam int unsigned PW        = IMAGE_WIDTH + WINDOW_SIZE - 1;
  localparam int unsigned PH        = IMAGE_HEIGHT + WINDOW_SIZE - 1;
  localparam int unsigned PLANE_IN  = PW * PH;
  localparam int unsigned PLANE_OUT = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ROW_W     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned COL_W     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned TAP_W     = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, FILT_WAIT, WR_REQ, ADVANCE, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [TAP_W-1:0]        wr_q, wr_d;
  logic [TAP_W-1:0]        wc_q, wc_d;
  logic                    memreq_q, memreq_d;
  logic [1:0]              memrw_q, memrw_d;
  logic [ADDR_WIDTH-1:0]   memaddr_q, memaddr_d;
  logic                    fen_q, fen_d;
  logic                    wlast_q, wlast_d;
  logic                    busy_q, busy_d;
  logic                    dne_q, dne_d;

  logic                    last_tap;
  logic                    last_pixel;

  // Tap address in the padded input plane, wrapping modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] rd_addr(
    input logic [CH_W-1:0]  c,
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] x,
    input logic [TAP_W-1:0] tr,
    input logic [TAP_W-1:0] tc
  );
    return ADDR_WIDTH'(c) * ADDR_WIDTH'(PLANE_IN)
         + (ADDR_WIDTH'(r) + ADDR_WIDTH'(tr)) * ADDR_WIDTH'(PW)
         + ADDR_WIDTH'(x) + ADDR_WIDTH'(tc);
  endfunction

  // Result address in the unpadded output plane.
  function automatic logic [ADDR_WIDTH-1:0] wr_addr(
    input logic [CH_W-1:0]  c,
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] x
  );
    return ADDR_WIDTH'(RESULT_BASE)
         + ADDR_WIDTH'(c) * ADDR_WIDTH'(PLANE_OUT)
         + ADDR_WIDTH'(r) * ADDR_WIDTH'(IMAGE_WIDTH)
         + ADDR_WIDTH'(x);
  endfunction

  assign last_tap   = (wr_q == TAP_W'(WINDOW_SIZE - 1)) && (wc_q == TAP_W'(WINDOW_SIZE - 1));
  assign last_pixel = (ch_q == CH_W'(CHANNELS - 1)) && (row_q == ROW_W'(IMAGE_HEIGHT - 1))
                   && (col_q == COL_W'(IMAGE_WIDTH - 1));

  // Next state and counters, then outputs decoded from the next state so
  // every output lands in a flop alongside the state it belongs to.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_d    = wr_q;
    wc_d    = wc_q;

    if (state_q != IDLE && Control_ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Control_STRT) begin
            ch_d    = '0;
            row_d   = '0;
            col_d   = '0;
            wr_d    = '0;
            wc_d    = '0;
            state_d = RD_REQ;
          end
        end
        RD_REQ: begin
          if (Control_MEMACK) begin
            if (wc_q == TAP_W'(WINDOW_SIZE - 1)) begin
              wc_d = '0;
              if (wr_q == TAP_W'(WINDOW_SIZE - 1)) begin
                wr_d    = '0;
                state_d = FILT_WAIT;
              end else begin
                wr_d = wr_q + TAP_W'(1);
              end
            end else begin
              wc_d = wc_q + TAP_W'(1);
            end
          end
        end
        FILT_WAIT: begin
          if (Control_FDNE) state_d = WR_REQ;
        end
        WR_REQ: begin
          if (Control_MEMACK) state_d = ADVANCE;
        end
        ADVANCE: begin
          if (last_pixel) begin
            state_d = DONE;
          end else begin
            state_d = RD_REQ;
            if (col_q == COL_W'(IMAGE_WIDTH - 1)) begin
              col_d = '0;
              if (row_q == ROW_W'(IMAGE_HEIGHT - 1)) begin
                row_d = '0;
                ch_d  = ch_q + CH_W'(1);
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    memreq_d  = 1'b0;
    memrw_d   = 2'b00;
    memaddr_d = '0;
    fen_d     = 1'b0;
    wlast_d   = 1'b0;
    busy_d    = (state_d != IDLE);
    dne_d     = (state_d == DONE);
    case (state_d)
      RD_REQ: begin
        memreq_d  = 1'b1;
        memrw_d   = 2'b10;
        memaddr_d = rd_addr(ch_d, row_d, col_d, wr_d, wc_d);
        fen_d     = 1'b1;
        wlast_d   = (wr_d == TAP_W'(WINDOW_SIZE - 1)) && (wc_d == TAP_W'(WINDOW_SIZE - 1));
      end
      FILT_WAIT: fen_d = 1'b1;
      WR_REQ: begin
        memreq_d  = 1'b1;
        memrw_d   = 2'b01;
        memaddr_d = wr_addr(ch_d, row_d, col_d);
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge Control_CLK or posedge Control_RST) begin
    if (Control_RST) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_q      <= '0;
      wc_q      <= '0;
      memreq_q  <= 1'b0;
      memrw_q   <= 2'b00;
      memaddr_q <= '0;
      fen_q     <= 1'b0;
      wlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      dne_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_q      <= wr_d;
      wc_q      <= wc_d;
      memreq_q  <= memreq_d;
      memrw_q   <= memrw_d;
      memaddr_q <= memaddr_d;
      fen_q     <= fen_d;
      wlast_q   <= wlast_d;
      busy_q    <= busy_d;
      dne_q     <= dne_d;
    end
  end

  assign Control_MEMREQ  = memreq_q;
  assign Control_MEMRW   = memrw_q;
  assign Control_MEMADDR = memaddr_q;
  assign Control_FEN     = fen_q;
  assign Control_WLAST   = wlast_q;
  assign Control_CH      = ch_q;
  assign Control_BUSY    = busy_q;
  assign Control_DNE     = dne_q;

endmodule

// File: doc/filter_sequencer.md
FILTER_SEQUENCER -- requirements
Module: filter_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 32, memory address width.
- WINDOW_SIZE, 3, odd window edge length WS.
- IMAGE_WIDTH, 512, output image width W.
- IMAGE_HEIGHT, 512, output image height H.
- CHANNELS, 1, number of colour planes C.
- RESULT_BASE, C*PW*PH, result image base address, where PW=W+WS-1 and PH=H+WS-1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Control_CLK, in, 1, clock; all logic on the rising edge.
- Control_RST, in, 1, reset, asynchronous, active-high.
- Control_STRT, in, 1, start request, sampled on the clock edge.
- Control_ABORT, in, 1, abandon current job.
- Control_MEMREQ, out, 1, memory request valid.
- Control_MEMACK, in, 1, memory accepted the request this edge.
- Control_MEMRW, out, 2, 2'b10 read, 2'b01 write, 2'b00 idle.
- Control_MEMADDR, out, ADDR_WIDTH, request address.
- Control_FEN, out, 1, filter enable.
- Control_WLAST, out, 1, current read is the last window tap.
- Control_FDNE, in, 1, filter result ready.
- Control_CH, out, max(1,clog2(C)), current channel.
- Control_BUSY, out, 1, job in progress.
- Control_DNE, out, 1, job-complete pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, RD_REQ, FILT_WAIT, WR_REQ, ADVANCE and DONE; all outputs SHALL be registered.
REQ-004 In IDLE, Control_STRT=1 SHALL clear the counters (ch, row, col, wr, wc) and enter RD_REQ; STRT SHALL be ignored in every other state.
REQ-005 In RD_REQ, the block SHALL drive MEMREQ=1, MEMRW=2'b10 and MEMADDR = ch*PW*PH + (row+wr)*PW + (col+wc).
- Taps SHALL be issued in raster order: wc fastest, then wr.
REQ-006 MEMREQ, MEMRW and MEMADDR SHALL hold stable until a clock edge with MEMACK=1; there is no timeout.
REQ-007 Each accepted read SHALL advance the tap; acceptance of tap (WS-1,WS-1) SHALL enter FILT_WAIT.
- WLAST SHALL be 1 only while that last tap is requested.
REQ-008 FEN SHALL rise on entry to RD_REQ and fall on exit from FILT_WAIT.
REQ-009 In FILT_WAIT, the block SHALL drive MEMREQ=0 and MEMRW=2'b00; FDNE=1 at an edge SHALL enter WR_REQ.
REQ-010 FDNE SHALL be ignored outside FILT_WAIT, and MEMACK SHALL be ignored outside RD_REQ and WR_REQ.
REQ-011 In WR_REQ, the block SHALL drive MEMREQ=1, MEMRW=2'b01 and MEMADDR = RESULT_BASE + ch*W*H + row*W + col; MEMACK SHALL enter ADVANCE.
REQ-012 ADVANCE SHALL last one cycle and step the pixel position:
- col increments; at W-1 it wraps to 0 and row increments.
- row wraps at H-1 to 0 and ch increments.
- After the last pixel (ch=C-1, row=H-1, col=W-1) the FSM SHALL enter DONE; otherwise it SHALL enter RD_REQ.
REQ-013 DONE SHALL assert DNE for exactly one cycle, then return to IDLE.
REQ-014 BUSY SHALL be 1 in every state except IDLE.
REQ-015 CH SHALL equal the current channel counter.
REQ-016 ABORT=1 at an edge in any non-IDLE state SHALL force IDLE with MEMREQ, FEN, WLAST, BUSY=0 and MEMRW=2'b00, and DNE SHALL NOT pulse.
REQ-017 ABORT SHALL take priority over a simultaneous MEMACK or FDNE.
REQ-018 All address arithmetic SHALL be computed in ADDR_WIDTH bits, with truncation modulo 2^ADDR_WIDTH.
REQ-019 With MEMACK tied to 1 and FDNE returned in the cycle after entering FILT_WAIT, each pixel SHALL take WS*WS + 3 cycles.

Reset
REQ-020 Control_RST=1 SHALL immediately force IDLE, all counters to 0 and all outputs to 0 (MEMRW=2'b00, MEMADDR=0), independent of the clock.
REQ-021 Reset asserted mid-job SHALL abandon the job without a DNE pulse; the next STRT after release SHALL restart at ch=0, row=0, col=0.

Verification
REQ-022 The bench SHALL cover these scenarios (W=H=4, WS=3, C=1, so PW=6, RESULT_BASE=36):
- Reset: assert RST mid-RD_REQ -> all outputs 0 on the same edge, BUSY=0.
- First pixel, ACK=1: STRT -> reads at 0,1,2,6,7,8,12,13,14 with WLAST only at 14; FDNE -> write at 36.
- Row wrap: pixel (0,3) reads start at 3; pixel (1,0) reads start at 6, and its write goes to 40.
- Backpressure: hold ACK=0 for 5 cycles at tap 4 -> MEMADDR stays 7 and MEMREQ=1; then continue at 8.
- Completion: after the write to 51 -> DNE one-cycle pulse, then BUSY=0; STRT during BUSY has no effect.
- Channels and abort: with C=2 (RESULT_BASE=72), pixel (ch1,0,0) reads start at 36 and writes to 88; ABORT in FILT_WAIT together with FDNE -> IDLE, DNE=0.
